// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the InvSubBytes engine FSM encoding.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NBYTES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/inv_s_box.sv
// Combinational AES inverse S-box (FIPS-197 table), one byte in, one byte out.
module inv_s_box
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] data_in,
  output logic [BYTE_W-1:0] data_out
);

  // Ascending outer range so that element 0 is the leftmost byte of the literal.
  localparam logic [0:255][BYTE_W-1:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign data_out = INV_SBOX[data_in];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: substitutes a 128-bit state LANES bytes per cycle, valid/ready on both sides.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  localparam int NGROUPS = NBYTES / LANES;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [STATE_W-1:0] r_work;
  logic [STATE_W-1:0] w_work_sub;
  logic [BYTE_W-1:0]  w_lane_in  [LANES];
  logic [BYTE_W-1:0]  w_lane_out [LANES];

  // Lane l of group cnt handles byte cnt*LANES+l (byte 0 sits at the MSB end).
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = r_work[STATE_W-1-BYTE_W*(int'(r_cnt)*LANES+l) -: BYTE_W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_s_box u_inv_s_box (
      .data_in  (w_lane_in[g]),
      .data_out (w_lane_out[g])
    );
  end

  always_comb begin
    w_work_sub = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_sub[STATE_W-1-BYTE_W*(int'(r_cnt)*LANES+l) -: BYTE_W] = w_lane_out[l];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_state   = '0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SUB;
      end
      ST_SUB: begin
        if (r_cnt == CNT_LAST) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        out_state = r_work;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_work <= '0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_cnt  <= '0;
      r_work <= in_state;
    end else if (r_state == ST_SUB) begin
      r_work <= w_work_sub;
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
